// File: rtl/rx_dispatch_pkg.sv
// rx_dispatch_pkg: state encoding, header offsets and constants for rx_frame_dispatch
package rx_dispatch_pkg;
    typedef enum logic [2:0] {
        ST_FLUSH,
        ST_IDLE,
        ST_DST,
        ST_SRC,
        ST_TYPE,
        ST_PAYLOAD,
        ST_DROP
    } state_t;
    localparam int CNT_W = 11;
    localparam int HDR_LEN = 14;
    localparam int DST_OFS = 0;
    localparam int SRC_OFS = 6;
    localparam int TYPE_OFS = 12;
    localparam logic [CNT_W-1:0] DST_LAST = CNT_W'(SRC_OFS - 1);
    localparam logic [CNT_W-1:0] SRC_LAST = CNT_W'(TYPE_OFS - 1);
    localparam logic [CNT_W-1:0] TYPE_HI = CNT_W'(TYPE_OFS);
    localparam logic [CNT_W-1:0] TYPE_LAST = CNT_W'(HDR_LEN - 1);
    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [15:0] ETYPE_ARP_DEF = 16'h0806;
    localparam logic [15:0] ETYPE_IP_DEF = 16'h0800;
    // byte idx of a MAC in wire order (idx 0 = msb byte)
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [47:0] sh;
        sh = mac << {idx, 3'b000};
        return sh[47:40];
    endfunction
endpackage

// File: rtl/rx_mac_filter.sv
// rx_mac_filter: serial compare of the destination MAC against local_mac and broadcast
module rx_mac_filter
    import rx_dispatch_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        en,
    input  logic [2:0]  idx,
    input  logic [7:0]  rx_data,
    input  logic [47:0] local_mac,
    output logic        match,
    output logic        is_bcast
);
    logic match_q, match_d, bcast_q, bcast_d;
    // idx 0 restarts the running compare; result includes the current byte
    always_comb begin
        match_d = (idx == 3'd0 || match_q) && rx_data == mac_byte(local_mac, idx);
        bcast_d = (idx == 3'd0 || bcast_q) && rx_data == mac_byte(BCAST_MAC, idx);
    end
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            match_q <= 1'b0;
            bcast_q <= 1'b0;
        end else if (en) begin
            match_q <= match_d;
            bcast_q <= bcast_d;
        end
    end
    assign match = match_d;
    assign is_bcast = bcast_d;
endmodule

// File: rtl/rx_frame_dispatch.sv
// rx_frame_dispatch: walks the Ethernet header, filters, and steers payload to ARP/IP consumers
module rx_frame_dispatch
    import rx_dispatch_pkg::*;
#(
    parameter int          MAX_FRAME_BYTES = 1518,
    parameter logic [15:0] ETYPE_ARP       = ETYPE_ARP_DEF,
    parameter logic [15:0] ETYPE_IP        = ETYPE_IP_DEF,
    parameter bit          PROMISCUOUS     = 1'b0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_active,
    input  logic [7:0]  rx_data,
    input  logic [47:0] local_mac,
    output logic [47:0] remote_mac,
    output logic [15:0] ethertype,
    output logic [7:0]  pay_data,
    output logic        arp_valid,
    output logic        ip_valid,
    output logic        broadcast,
    output logic        frame_done,
    output logic        frame_drop
);
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [47:0]        src_sh_q, src_sh_d, remote_mac_q, remote_mac_d;
    logic [15:0]        ethertype_q, ethertype_d, etype;
    logic [7:0]         type_hi_q, type_hi_d, pay_data_q, pay_data_d;
    logic               bcast_sh_q, bcast_sh_d, broadcast_q, broadcast_d;
    logic               arp_valid_q, arp_valid_d, ip_valid_q, ip_valid_d;
    logic               frame_done_q, frame_done_d, frame_drop_q, frame_drop_d;
    logic               f_match, f_bcast;

    rx_mac_filter u_filter (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (rx_active && (state_q == ST_IDLE || state_q == ST_DST)),
        .idx       (cnt_q[2:0]),
        .rx_data   (rx_data),
        .local_mac (local_mac),
        .match     (f_match),
        .is_bcast  (f_bcast)
    );

    always_comb begin
        state_d = state_q;
        cnt_d = (rx_active && state_q != ST_FLUSH) ? ((&cnt_q) ? cnt_q : cnt_q + 1'b1) : '0;
        src_sh_d = src_sh_q;
        type_hi_d = type_hi_q;
        bcast_sh_d = bcast_sh_q;
        remote_mac_d = remote_mac_q;
        ethertype_d = ethertype_q;
        broadcast_d = broadcast_q;
        pay_data_d = rx_data;
        arp_valid_d = 1'b0;
        ip_valid_d = 1'b0;
        frame_done_d = 1'b0;
        frame_drop_d = 1'b0;
        etype = {type_hi_q, rx_data};
        if (!rx_active) begin
            state_d = ST_IDLE;
            frame_done_d = state_q == ST_PAYLOAD;
            frame_drop_d = state_q inside {ST_DST, ST_SRC, ST_TYPE, ST_DROP};
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_DST;
                ST_DST: begin
                    if (cnt_q == DST_LAST) begin
                        bcast_sh_d = f_bcast;
                        state_d = (PROMISCUOUS || f_match || f_bcast) ? ST_SRC : ST_DROP;
                    end
                end
                ST_SRC: begin
                    src_sh_d = {src_sh_q[39:0], rx_data};
                    if (cnt_q == SRC_LAST) state_d = ST_TYPE;
                end
                // header results are committed only once the whole frame header is known good
                ST_TYPE: begin
                    if (cnt_q == TYPE_HI) begin
                        type_hi_d = rx_data;
                    end else if (cnt_q == TYPE_LAST && (etype == ETYPE_ARP || etype == ETYPE_IP)) begin
                        remote_mac_d = src_sh_q;
                        ethertype_d = etype;
                        broadcast_d = bcast_sh_q;
                        state_d = ST_PAYLOAD;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                ST_PAYLOAD: begin
                    if (cnt_q >= CNT_W'(MAX_FRAME_BYTES)) begin
                        state_d = ST_DROP;
                    end else begin
                        arp_valid_d = ethertype_q == ETYPE_ARP;
                        ip_valid_d = ethertype_q == ETYPE_IP;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_FLUSH;
            cnt_q <= '0;
            src_sh_q <= '0;
            type_hi_q <= '0;
            bcast_sh_q <= 1'b0;
            remote_mac_q <= '0;
            ethertype_q <= '0;
            broadcast_q <= 1'b0;
            pay_data_q <= '0;
            arp_valid_q <= 1'b0;
            ip_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            src_sh_q <= src_sh_d;
            type_hi_q <= type_hi_d;
            bcast_sh_q <= bcast_sh_d;
            remote_mac_q <= remote_mac_d;
            ethertype_q <= ethertype_d;
            broadcast_q <= broadcast_d;
            pay_data_q <= pay_data_d;
            arp_valid_q <= arp_valid_d;
            ip_valid_q <= ip_valid_d;
            frame_done_q <= frame_done_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    assign remote_mac = remote_mac_q;
    assign ethertype = ethertype_q;
    assign pay_data = pay_data_q;
    assign arp_valid = arp_valid_q;
    assign ip_valid = ip_valid_q;
    assign broadcast = broadcast_q;
    assign frame_done = frame_done_q;
    assign frame_drop = frame_drop_q;
endmodule

// File: tb/tb_rx_frame_dispatch.sv
// tb_rx_frame_dispatch: directed frames with hand-computed expectations for rx_frame_dispatch
module tb_rx_frame_dispatch;
    localparam logic [47:0] LMAC = 48'h02_00_5E_10_20_30;
    localparam logic [47:0] SRC_A = 48'hA0_B1_C2_D3_E4_F5;
    localparam logic [47:0] SRC_B = 48'h11_22_33_44_55_66;
    localparam logic [47:0] SRC_C = 48'h77_88_99_AA_BB_CC;
    localparam logic [47:0] SRC_D = 48'h0A_0B_0C_0D_0E_0F;
    localparam logic [47:0] SRC_E = 48'hDE_AD_BE_EF_00_01;
    localparam logic [47:0] SRC_F = 48'h5A_5A_5A_A5_A5_A5;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rx_active = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic [47:0] local_mac = LMAC;
    logic [47:0] remote_mac;
    logic [15:0] ethertype;
    logic [7:0]  pay_data;
    logic        arp_valid, ip_valid, broadcast, frame_done, frame_drop;

    int errors = 0;
    int checks = 0;
    logic [7:0] fb [0:1699];
    int ip_cnt, arp_cnt, done_cnt, drop_cnt, done_mid, drop_mid, pay_err, overlap, first_v, last_v;
    logic rst_snap;

    rx_frame_dispatch dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx_active  (rx_active),
        .rx_data    (rx_data),
        .local_mac  (local_mac),
        .remote_mac (remote_mac),
        .ethertype  (ethertype),
        .pay_data   (pay_data),
        .arp_valid  (arp_valid),
        .ip_valid   (ip_valid),
        .broadcast  (broadcast),
        .frame_done (frame_done),
        .frame_drop (frame_drop)
    );

    always #5 clock = ~clock;

    task automatic fill(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et, input int n);
        for (int i = 0; i < 6; i++) begin
            fb[i] = dst[47-8*i -: 8];
            fb[6+i] = src[47-8*i -: 8];
        end
        fb[12] = et[15:8];
        fb[13] = et[7:0];
        for (int i = 14; i < n; i++) fb[i] = 8'(i * 7 + 3);
    endtask

    // one clock; k is the index of the byte driven into this edge, -1 for idle
    task automatic step(input int k);
        @(posedge clock);
        #1;
        if (ip_valid) ip_cnt++;
        if (arp_valid) arp_cnt++;
        if (ip_valid || arp_valid) begin
            if (k < 0) pay_err++;
            else begin
                if (first_v < 0) first_v = k;
                last_v = k;
                if (pay_data !== fb[k]) pay_err++;
            end
        end
        if (frame_done) begin done_cnt++; if (k >= 0) done_mid++; end
        if (frame_drop) begin drop_cnt++; if (k >= 0) drop_mid++; end
        if ((ip_valid && arp_valid) || (frame_done && frame_drop)) overlap++;
    endtask

    task automatic run_frame(input int n, input int gap, input int rst_at);
        ip_cnt = 0; arp_cnt = 0; done_cnt = 0; drop_cnt = 0; done_mid = 0; drop_mid = 0;
        pay_err = 0; overlap = 0; first_v = -1; last_v = -1; rst_snap = 1'b0;
        for (int k = 0; k < n; k++) begin
            rx_active = 1'b1;
            rx_data = fb[k];
            reset_n = (k != rst_at);
            step(k);
            if (k == rst_at)
                rst_snap = !ip_valid && !arp_valid && pay_data == 8'h00 && remote_mac == 48'h0 &&
                           ethertype == 16'h0 && !broadcast && !frame_done && !frame_drop;
        end
        reset_n = 1'b1;
        rx_active = 1'b0;
        rx_data = 8'h00;
        for (int g = 0; g < gap; g++) step(-1);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        rx_active = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checks++; if (remote_mac !== 48'h0) begin errors++; $display("FAIL rst_remote_mac got %h want 0", remote_mac); end
        checks++; if (ethertype !== 16'h0) begin errors++; $display("FAIL rst_ethertype got %h want 0", ethertype); end
        checks++; if ({arp_valid, ip_valid} !== 2'b00) begin errors++; $display("FAIL rst_valids got %b want 00", {arp_valid, ip_valid}); end
        checks++; if ({frame_done, frame_drop, broadcast} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {frame_done, frame_drop, broadcast}); end
        checks++; if (pay_data !== 8'h00) begin errors++; $display("FAIL rst_pay_data got %h want 00", pay_data); end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_unicast_ip;
        fill(LMAC, SRC_A, 16'h0800, 64);
        run_frame(64, 2, -1);
        checks++; if (ip_cnt !== 50) begin errors++; $display("FAIL uni_ip_cnt got %0d want 50", ip_cnt); end
        checks++; if (arp_cnt !== 0) begin errors++; $display("FAIL uni_arp_cnt got %0d want 0", arp_cnt); end
        checks++; if (first_v !== 14 || last_v !== 63) begin errors++; $display("FAIL uni_span got %0d..%0d want 14..63", first_v, last_v); end
        checks++; if (pay_err !== 0) begin errors++; $display("FAIL uni_pay_data got %0d bad want 0", pay_err); end
        checks++; if (done_cnt !== 1 || done_mid !== 0) begin errors++; $display("FAIL uni_done got %0d/%0d want 1/0", done_cnt, done_mid); end
        checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL uni_drop got %0d want 0", drop_cnt); end
        checks++; if (remote_mac !== SRC_A) begin errors++; $display("FAIL uni_remote_mac got %h want %h", remote_mac, SRC_A); end
        checks++; if (ethertype !== 16'h0800) begin errors++; $display("FAIL uni_ethertype got %h want 0800", ethertype); end
        checks++; if (broadcast !== 1'b0) begin errors++; $display("FAIL uni_broadcast got %b want 0", broadcast); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL uni_exclusive got %0d want 0", overlap); end
    endtask

    task automatic test_bcast_arp;
        fill(48'hFFFF_FFFF_FFFF, SRC_B, 16'h0806, 46);
        run_frame(46, 2, -1);
        checks++; if (arp_cnt !== 32) begin errors++; $display("FAIL arp_cnt got %0d want 32", arp_cnt); end
        checks++; if (ip_cnt !== 0) begin errors++; $display("FAIL arp_ip_cnt got %0d want 0", ip_cnt); end
        checks++; if (pay_err !== 0 || last_v !== 45) begin errors++; $display("FAIL arp_pay got err=%0d last=%0d want 0/45", pay_err, last_v); end
        checks++; if (broadcast !== 1'b1) begin errors++; $display("FAIL arp_broadcast got %b want 1", broadcast); end
        checks++; if (remote_mac !== SRC_B || ethertype !== 16'h0806) begin errors++; $display("FAIL arp_hdr got %h/%h want %h/0806", remote_mac, ethertype, SRC_B); end
        checks++; if (done_cnt !== 1 || drop_cnt !== 0) begin errors++; $display("FAIL arp_pulses got done=%0d drop=%0d want 1/0", done_cnt, drop_cnt); end
    endtask

    task automatic test_filtered;
        fill(LMAC ^ 48'h1, SRC_C, 16'h0800, 60);
        run_frame(60, 2, -1);
        checks++; if (ip_cnt + arp_cnt !== 0) begin errors++; $display("FAIL mac_valids got %0d want 0", ip_cnt + arp_cnt); end
        checks++; if (drop_cnt !== 1 || drop_mid !== 0) begin errors++; $display("FAIL mac_drop got %0d/%0d want 1/0", drop_cnt, drop_mid); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL mac_done got %0d want 0", done_cnt); end
        checks++; if (remote_mac !== SRC_B) begin errors++; $display("FAIL mac_remote got %h want %h", remote_mac, SRC_B); end
        fill(LMAC, SRC_C, 16'h86DD, 60);
        run_frame(60, 2, -1);
        checks++; if (ip_cnt + arp_cnt !== 0) begin errors++; $display("FAIL type_valids got %0d want 0", ip_cnt + arp_cnt); end
        checks++; if (drop_cnt !== 1 || drop_mid !== 0) begin errors++; $display("FAIL type_drop got %0d/%0d want 1/0", drop_cnt, drop_mid); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL type_done got %0d want 0", done_cnt); end
        checks++; if (remote_mac !== SRC_B || ethertype !== 16'h0806) begin errors++; $display("FAIL type_hdr got %h/%h want %h/0806", remote_mac, ethertype, SRC_B); end
    endtask

    task automatic test_back_to_back;
        fill(LMAC, SRC_D, 16'h0800, 10);
        run_frame(10, 1, -1);
        checks++; if (drop_cnt !== 1 || drop_mid !== 0) begin errors++; $display("FAIL runt_drop got %0d/%0d want 1/0", drop_cnt, drop_mid); end
        checks++; if (done_cnt + ip_cnt + arp_cnt !== 0) begin errors++; $display("FAIL runt_quiet got %0d want 0", done_cnt + ip_cnt + arp_cnt); end
        checks++; if (remote_mac !== SRC_B) begin errors++; $display("FAIL runt_remote got %h want %h", remote_mac, SRC_B); end
        fill(LMAC, SRC_E, 16'h0800, 60);
        run_frame(60, 2, -1);
        checks++; if (ip_cnt !== 46 || pay_err !== 0) begin errors++; $display("FAIL b2b_ip got cnt=%0d err=%0d want 46/0", ip_cnt, pay_err); end
        checks++; if (done_cnt !== 1 || drop_cnt !== 0) begin errors++; $display("FAIL b2b_pulses got done=%0d drop=%0d want 1/0", done_cnt, drop_cnt); end
        checks++; if (remote_mac !== SRC_E || broadcast !== 1'b0) begin errors++; $display("FAIL b2b_hdr got %h/%b want %h/0", remote_mac, broadcast, SRC_E); end
    endtask

    task automatic test_overlength;
        fill(LMAC, SRC_A, 16'h0800, 1600);
        run_frame(1600, 2, -1);
        checks++; if (ip_cnt !== 1504) begin errors++; $display("FAIL ovl_ip_cnt got %0d want 1504", ip_cnt); end
        checks++; if (last_v !== 1517) begin errors++; $display("FAIL ovl_last got %0d want 1517", last_v); end
        checks++; if (pay_err !== 0) begin errors++; $display("FAIL ovl_pay got %0d want 0", pay_err); end
        checks++; if (done_cnt !== 0) begin errors++; $display("FAIL ovl_done got %0d want 0", done_cnt); end
        checks++; if (drop_cnt !== 1 || drop_mid !== 0) begin errors++; $display("FAIL ovl_drop got %0d/%0d want 1/0", drop_cnt, drop_mid); end
    endtask

    task automatic test_reset_mid;
        fill(LMAC, SRC_F, 16'h0800, 64);
        run_frame(64, 2, 20);
        checks++; if (rst_snap !== 1'b1) begin errors++; $display("FAIL rstm_outputs got %b want 1", rst_snap); end
        checks++; if (ip_cnt !== 6 || last_v !== 19) begin errors++; $display("FAIL rstm_ip got cnt=%0d last=%0d want 6/19", ip_cnt, last_v); end
        checks++; if (done_cnt + drop_cnt !== 0) begin errors++; $display("FAIL rstm_pulses got %0d want 0", done_cnt + drop_cnt); end
        checks++; if (remote_mac !== 48'h0) begin errors++; $display("FAIL rstm_remote got %h want 0", remote_mac); end
        fill(LMAC, SRC_A, 16'h0800, 60);
        run_frame(60, 2, -1);
        checks++; if (ip_cnt !== 46 || done_cnt !== 1) begin errors++; $display("FAIL rstm_next got cnt=%0d done=%0d want 46/1", ip_cnt, done_cnt); end
        checks++; if (remote_mac !== SRC_A) begin errors++; $display("FAIL rstm_next_remote got %h want %h", remote_mac, SRC_A); end
    endtask

    initial begin
        test_reset;
        test_unicast_ip;
        test_bcast_arp;
        test_filtered;
        test_back_to_back;
        test_overlength;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
